// File: rtl/pwm_capture_if.sv
// rtl/pwm_capture_if.sv - command/result bundle between pwm_capture and its controller
//
// Signals:
//   in      PWM waveform to measure (driven by pin or looped-back generator)
//   sel     command: 0 none, 1 clear ovf, 2 restart, 3 reserved
//   period  cycles between the last two rising edges
//   high    cycles the waveform was high within that period
//   valid   one-cycle pulse marking a fresh period/high pair
//   ovf     sticky timeout flag
//   busy    capture state machine is armed (not IDLE)
// Modports: master = controller side, slave = pwm_capture.
interface pwm_capture_if;
   logic        in;
   logic [1:0]  sel;
   logic [15:0] period;
   logic [15:0] high;
   logic        valid;
   logic        ovf;
   logic        busy;

   modport master (
      output in, sel,
      input  period, high, valid, ovf, busy
   );

   modport slave (
      input  in, sel,
      output period, high, valid, ovf, busy
   );
endinterface

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures period and high time of a PWM waveform in clock cycles
//
// Ports:
//   clk   sole clock, rising edge
//   rst   synchronous active-high reset
//   bus   pwm_capture_if.slave (in, sel, period, high, valid, ovf, busy)
// Build option:
//   PWM_CAPTURE_SYNC_EN  route `in` through a 2-flop synchronizer (+2 cycles latency)
module pwm_capture (
   input  logic           clk,
   input  logic           rst,
   pwm_capture_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   state_t      state, state_nxt;
   logic        s, prev;
   logic        rise, fall;
   logic        publish, timeout;
   logic        cmd_clr, cmd_restart;
   logic [15:0] cnt, hcnt;
   logic [15:0] cnt_nxt, hcnt_nxt;
   logic [15:0] period_q, high_q;
   logic        valid_q, ovf_q, busy_q;

`ifdef PWM_CAPTURE_SYNC_EN
   // Reset to 1 so a pin already high at reset does not look like a rise.
   logic [1:0] sync_q;
   always_ff @(posedge clk) begin
      if (rst) sync_q <= 2'b11;
      else     sync_q <= {sync_q[0], bus.in};
   end
   assign s = sync_q[1];
`else
   assign s = bus.in;
`endif

   // prev resets high: an input already high out of reset is not an edge.
   always_ff @(posedge clk) begin
      if (rst) prev <= 1'b1;
      else     prev <= s;
   end

   assign rise        = s & ~prev;
   assign fall        = ~s & prev;
   assign cmd_clr     = (bus.sel == 2'd1);
   assign cmd_restart = (bus.sel == 2'd2);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      publish   = 1'b0;
      timeout   = 1'b0;
      case (state)
         IDLE: begin
            // First rise only arms; the partial period before it is discarded.
            if (rise) state_nxt = HIGH;
         end
         HIGH: begin
            if (cnt == CNT_MAX && !rise) timeout   = 1'b1;
            else if (fall)               state_nxt = LOW;
         end
         LOW: begin
            if (rise) begin
               publish   = 1'b1;
               state_nxt = HIGH;
            end else if (cnt == CNT_MAX) begin
               timeout = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (timeout) state_nxt = IDLE;
      // Restart overrides everything happening in the same cycle.
      if (cmd_restart) begin
         state_nxt = IDLE;
         publish   = 1'b0;
         timeout   = 1'b0;
      end
   end

   // Counters saturate instead of wrapping; the timeout catches the limit.
   always_comb begin
      cnt_nxt  = cnt;
      hcnt_nxt = hcnt;
      if (cmd_restart) begin
         cnt_nxt  = '0;
         hcnt_nxt = '0;
      end else if (rise) begin
         cnt_nxt  = 16'd1;
         hcnt_nxt = 16'd1;
      end else begin
         if (cnt != CNT_MAX)       cnt_nxt  = cnt + 16'd1;
         if (s && hcnt != CNT_MAX) hcnt_nxt = hcnt + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         hcnt     <= '0;
         period_q <= '0;
         high_q   <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         cnt     <= cnt_nxt;
         hcnt    <= hcnt_nxt;
         valid_q <= publish;
         busy_q  <= (state_nxt != IDLE);
         if (publish) begin
            period_q <= cnt;
            high_q   <= hcnt;
         end
         // A same-cycle timeout beats a clear request.
         if (timeout)      ovf_q <= 1'b1;
         else if (cmd_clr) ovf_q <= 1'b0;
      end
   end

   assign bus.period = period_q;
   assign bus.high   = high_q;
   assign bus.valid  = valid_q;
   assign bus.ovf    = ovf_q;
   assign bus.busy   = busy_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed self-checking bench for pwm_capture
module tb_pwm_capture;

`ifdef PWM_CAPTURE_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   localparam int GEN_TOP = 9;
   localparam int GEN_CMP = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   pwm_capture_if bus ();

   pwm_capture dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int n_checks  = 0;
   int n_fail    = 0;
   int idx       = 0;
   int vcnt      = 0;
   int first_idx = -1;
   int last_idx  = -1;
   int exp_p     = 0;
   int exp_h     = 0;
   int exp_gap   = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_stats(input int p, input int h, input int gap);
      vcnt      = 0;
      first_idx = -1;
      last_idx  = -1;
      idx       = 0;
      exp_p     = p;
      exp_h     = h;
      exp_gap   = gap;
   endtask

   // Drive `in`=v for n cycles; every valid pulse is checked against exp_p/exp_h.
   task automatic drive(input logic v, input int n);
      for (int i = 0; i < n; i++) begin
         bus.in = v;
         @(posedge clk);
         #1;
         idx++;
         if (bus.valid === 1'b1) begin
            vcnt++;
            check("pub_period", int'(bus.period), exp_p);
            check("pub_high", int'(bus.high), exp_h);
            if (exp_gap != 0 && last_idx >= 0) check("pub_gap", idx - last_idx, exp_gap);
            if (first_idx < 0) first_idx = idx;
            last_idx = idx;
         end
      end
   endtask

   task automatic restart();
      bus.sel = 2'd2;
      drive(bus.in, 1);
      bus.sel = 2'd0;
   endtask

   initial begin
      int g;
      int gen_p;
      int gen_h;

      bus.in  = 1'b1;
      bus.sel = 2'd0;

      // Reset with in held high.
      rst = 1'b1;
      drive(1'b1, 10);
      check("rst_period", int'(bus.period), 0);
      check("rst_high", int'(bus.high), 0);
      check("rst_valid", int'(bus.valid), 0);
      check("rst_ovf", int'(bus.ovf), 0);
      check("rst_busy", int'(bus.busy), 0);
      rst = 1'b0;

      // 3 high / 5 low: rises at steps 6,14,22,30 -> three publishes.
      clear_stats(8, 3, 8);
      drive(1'b0, 5);
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 3);
         drive(1'b0, 5);
      end
      check("t1_count", vcnt, 3);
      check("t1_first", first_idx, 14 + LAT);
      check("t1_busy", int'(bus.busy), 1);

      // 1 high / 1 low: 10 rises -> 9 publishes, every 2 cycles.
      restart();
      clear_stats(2, 1, 2);
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, 1);
         drive(1'b0, 1);
      end
      drive(1'b0, 3);
      check("t2_count", vcnt, 9);

      // Arm then hold low: timeout 65535 cycles after the rise.
      restart();
      clear_stats(0, 0, 0);
      drive(1'b0, 3);
      drive(1'b1, 1);
      drive(1'b0, 65534 + LAT);
      check("t3_ovf_early", int'(bus.ovf), 0);
      check("t3_busy_early", int'(bus.busy), 1);
      drive(1'b0, 1);
      check("t3_ovf", int'(bus.ovf), 1);
      check("t3_busy", int'(bus.busy), 0);
      drive(1'b0, 3);
      check("t3_ovf_sticky", int'(bus.ovf), 1);
      check("t3_count", vcnt, 0);
      bus.sel = 2'd1;
      drive(1'b0, 1);
      bus.sel = 2'd0;
      check("t3_ovf_clr", int'(bus.ovf), 0);

      // Restart coinciding with the publishing rise.
      restart();
      clear_stats(8, 3, 0);
      drive(1'b0, 2);
      drive(1'b1, 3);
      drive(1'b0, 5);
      drive(1'b1, 3);
      drive(1'b0, 5);
      check("t4_pre_count", vcnt, 1);
      drive(1'b1, LAT);
      bus.sel = 2'd2;
      drive(1'b1, 1);
      bus.sel = 2'd0;
      check("t4_valid", int'(bus.valid), 0);
      check("t4_busy", int'(bus.busy), 0);
      check("t4_period_kept", int'(bus.period), 8);
      check("t4_high_kept", int'(bus.high), 3);
      clear_stats(8, 4, 0);
      drive(1'b1, 2 - LAT);
      drive(1'b0, 5);
      drive(1'b1, 4);
      drive(1'b0, 4);
      drive(1'b1, 4);
      drive(1'b0, 4);
      check("t4_count", vcnt, 1);

      // Reset mid-period while in LOW.
      check("t5_busy_pre", int'(bus.busy), 1);
      rst = 1'b1;
      drive(1'b0, 1);
      rst = 1'b0;
      check("t5_period", int'(bus.period), 0);
      check("t5_high", int'(bus.high), 0);
      check("t5_valid", int'(bus.valid), 0);
      check("t5_busy", int'(bus.busy), 0);
      clear_stats(8, 3, 0);
      drive(1'b0, 3);
      drive(1'b1, 3);
      drive(1'b0, 5);
      check("t5_arm_only", vcnt, 0);
      drive(1'b1, 3);
      drive(1'b0, 5);
      check("t5_count", vcnt, 1);

      // Looped-back generator model: counter 0..top, output high while cnt < cmp.
      gen_p = GEN_TOP + 1;
      gen_h = 0;
      for (int c = 0; c <= GEN_TOP; c++) if (c < GEN_CMP) gen_h++;
      restart();
      drive(1'b0, 2);
      clear_stats(gen_p, gen_h, gen_p);
      g = 0;
      for (int k = 0; k < 4 * gen_p; k++) begin
         drive((g < GEN_CMP) ? 1'b1 : 1'b0, 1);
         g = (g == GEN_TOP) ? 0 : g + 1;
      end
      check("t6_count", vcnt, 3);
      check("t6_period", int'(bus.period), 10);
      check("t6_high", int'(bus.high), 4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

PWM capture block: measures period and high time of an incoming PWM waveform in clock cycles. Receive-side counterpart of the team's register-programmed PWM generator (cmp/top/cnt writes via `sel`/`d`). Sits between an external PWM pin, or a looped-back generator output, and the control logic. Results are published as a valid-pulsed pair.

## Interface
- No parameters; all counters 16 bit.
- `clk`  in  1  sole clock, rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `in`  in  1  PWM waveform to measure.
- `sel`  in  2  command: 0 none, 1 clear `ovf`, 2 restart (force IDLE), 3 reserved (no-op).
- `period`  out  16  cycles between last two rising edges.
- `high`  out  16  cycles `in` was high within that period.
- `valid`  out  1  one-cycle pulse; `period`/`high` updated this cycle.
- `ovf`  out  1  sticky timeout flag.
- `busy`  out  1  high when state is not IDLE.

## Operation
- Sampled input `s` = `in` (or synchronized `in`, see Configuration). `prev` = `s` delayed one cycle.
- Edges: rise = `s & ~prev`; fall = `~s & prev`.
- Counters:
  - `cnt`: set to 1 on rise, else +1.
  - `hcnt`: set to 1 on rise, else +1 when `s`=1, else hold.
- State machine:
  - IDLE: waiting for first rise; no publish. On rise -> HIGH.
  - HIGH: on fall -> LOW.
  - LOW: on rise, publish `period<=cnt`, `high<=hcnt`, `valid<=1` -> HIGH.
- The first rise after reset or restart only arms the block. A partial first period is never published.
- Timeout: in HIGH or LOW, if `cnt`==16'hFFFF and no rise this cycle -> `ovf<=1`, state IDLE, no `valid`. Constant-high or constant-low input therefore times out. Counters never wrap.
- `sel`=1: `ovf<=0`. If a timeout occurs in the same cycle, set wins (`ovf`=1).
- `sel`=2: state IDLE, counters cleared. Restart wins over a same-cycle rise or timeout: no publish, `ovf` unchanged.
- `period`/`high` hold their last published values until the next publish.

## Timing
- Reset values: `period`=0, `high`=0, `valid`=0, `ovf`=0, `busy`=0, state IDLE, `cnt`=`hcnt`=0.
- `prev` resets to 1, so an `in` already high at reset is not a rise; a 0→1 transition is required.
- Latency: rise seen on `s` in cycle n -> `valid`=1 and new values visible in cycle n+1, for exactly one cycle.
- Add synchronizer latency from `in` to `s` when enabled.
- Minimum measurable waveform: period 2, high 1, giving back-to-back publishes every 2 cycles.
- Maximum period 65535. A period of 65536 or more gives `ovf`.
- `busy` is registered from state: 1 in HIGH/LOW.

## Configuration
- `PWM_CAPTURE_SYNC_EN` defined:
  - `in` passes through a 2-flop synchronizer before becoming `s`; adds 2 cycles of latency from `in` to `valid`.
  - Synchronizer flops reset to 1.
- Macro undefined: `s` = `in` directly; `in` must be synchronous to `clk`.
- Measured `period`/`high` values are identical in both builds; only latency differs.

## Test plan
- Reset with `in`=1 held for 10 cycles, then `in` toggles 3 high / 5 low:
  - No `valid` on the first rise.
  - On the second rise, `valid` pulses with `period`=8, `high`=3, then repeats every 8 cycles.
- `in` 1 high / 1 low -> `valid` every 2 cycles with `period`=2, `high`=1; no missed publishes.
- Arm with a rise, then hold `in`=0:
  - 65535 cycles after the rise, `ovf`=1, `busy`=0, no `valid`.
  - `sel`=1 for one cycle -> `ovf`=0.
- `sel`=2 in the same cycle as the rise that would publish:
  - No `valid`, `busy`=0, old `period`/`high` retained.
  - The next full period publishes correctly.
- `rst` asserted mid-period (state LOW) -> next cycle all outputs 0 and state IDLE; a full period is needed before the first `valid`.
- Loop back the PWM generator with top=9, cmp=4:
  - `period` equals the generator's cycle length.
  - `high` matches its high time, checked against the generator model.
  - Run with and without `PWM_CAPTURE_SYNC_EN`; values are the same in both builds.
